// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline stage holding up to DEPTH beats of a packed
// stage bundle, with valid/ready handshake, stall/bubble/flush hazard controls
// and a default (NOP) bundle shown whenever the stage is empty.
// Optional build macro: PIPE_STAGE_PERF_EN adds stall/bubble/flush cycle counters.
module pipe_stage_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [WIDTH-1:0]             default_val,
    input  logic                         stall,
    input  logic                         bubble,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  bubble_cycles,
    output logic [31:0]                  flush_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Handshake and hazard decode; full stage may accept while it pops
    always_comb begin
        out_valid = (count_q != '0);
        in_ready  = !stall && !flush &&
                    ((count_q < CNT_W'(DEPTH)) || (out_ready && (count_q != '0)));
        push      = in_valid && in_ready && !bubble;
        pop       = out_valid && out_ready && !stall && !flush;
        out_data  = out_valid ? mem_q[rd_ptr_q] : default_val;
        count     = count_q;
    end

    // Next pointer/count state; pointers wrap at DEPTH-1 for any DEPTH
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register; reset empties the stage without a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_cycles_q, bubble_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    // Hazard counters follow the flush > stall > bubble priority
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        bubble_cycles_d = bubble_cycles_q;
        flush_cycles_d  = flush_cycles_q;
        if (flush) begin
            flush_cycles_d = flush_cycles_q + 32'd1;
        end else if (stall) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else if (bubble) begin
            bubble_cycles_d = bubble_cycles_q + 32'd1;
        end
    end

    // Counter registers, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q  <= '0;
            bubble_cycles_q <= '0;
            flush_cycles_q  <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            bubble_cycles_q <= bubble_cycles_d;
            flush_cycles_q  <= flush_cycles_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_cycles = bubble_cycles_q;
    assign flush_cycles  = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=3 instance share
// the same stimulus; each scenario checks the instance it is aimed at.
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] default_val;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        out_ready;

    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  count2;
    logic        in_ready3, out_valid3;
    logic [31:0] out_data3;
    logic [1:0]  count3;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cyc2, bubble_cyc2, flush_cyc2;
    logic [31:0] stall_cyc3, bubble_cyc3, flush_cyc3;
`endif

    int n_checks;
    int n_errors;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .default_val(default_val), .stall(stall), .bubble(bubble), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .count(count2)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall_cyc2), .bubble_cycles(bubble_cyc2), .flush_cycles(flush_cyc2)
`endif
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .default_val(default_val), .stall(stall), .bubble(bubble), .flush(flush),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .count(count3)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall_cyc3), .bubble_cycles(bubble_cyc3), .flush_cycles(flush_cyc3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle push with current out_ready
    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        default_val = 32'h0000_0013;
        stall       = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        #2;
        chk("rst_valid",  32'(out_valid2), 32'd0);
        chk("rst_data",   out_data2, 32'h0000_0013);
        chk("rst_count",  32'(count2), 32'd0);
        chk("rst_ready",  32'(in_ready2), 32'd1);
        chk("rst_data3",  out_data3, 32'h0000_0013);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // First beat after reset, one-cycle latency
        push(32'hA5A5_A5A5);
        #2;
        chk("first_valid", 32'(out_valid2), 32'd1);
        chk("first_data",  out_data2, 32'hA5A5_A5A5);
        chk("first_count", 32'(count2), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #2;
        chk("clr_count", 32'(count2), 32'd0);

        // Fill DEPTH=3 with out_ready low, beat 4 refused
        push(32'd1);
        push(32'd2);
        push(32'd3);
        #2;
        chk("fill_count3", 32'(count3), 32'd3);
        chk("fill_ready3", 32'(in_ready3), 32'd0);
        chk("fill_count2", 32'(count2), 32'd2);
        chk("fill_ready2", 32'(in_ready2), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'd4;
        tick();
        #2;
        chk("full_hold3", 32'(count3), 32'd3);
        chk("full_head3", out_data3, 32'd1);

        // Drain with beat 4 entering as 1 leaves
        out_ready = 1'b1;
        #2;
        chk("drain_ready3", 32'(in_ready3), 32'd1);
        chk("drain_d1", out_data3, 32'd1);
        tick();
        in_valid = 1'b0;
        #2;
        chk("drain_d2", out_data3, 32'd2);
        chk("drain_cnt", 32'(count3), 32'd3);
        tick();
        #2;
        chk("drain_d3", out_data3, 32'd3);
        tick();
        #2;
        chk("drain_d4", out_data3, 32'd4);
        tick();
        #2;
        chk("drain_empty", 32'(out_valid3), 32'd0);
        chk("drain_empty2", 32'(out_valid2), 32'd0);

        // Full DEPTH=2 with simultaneous push and pop
        out_ready = 1'b0;
        push(32'd7);
        push(32'd8);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'd9;
        #2;
        chk("fp_ready", 32'(in_ready2), 32'd1);
        chk("fp_d7", out_data2, 32'd7);
        tick();
        in_valid = 1'b0;
        #2;
        chk("fp_count", 32'(count2), 32'd2);
        chk("fp_d8", out_data2, 32'd8);
        tick();
        #2;
        chk("fp_d9", out_data2, 32'd9);
        tick();
        #2;
        chk("fp_empty", 32'(out_valid2), 32'd0);

        // Stall holds everything
        out_ready = 1'b0;
        push(32'd5);
        push(32'd6);
        stall     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("st_ready", 32'(in_ready2), 32'd0);
            chk("st_data",  out_data2, 32'd5);
            chk("st_count", 32'(count2), 32'd2);
            tick();
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("st_rel_d5", out_data2, 32'd5);
        tick();
        #2;
        chk("st_rel_d6", out_data2, 32'd6);
        tick();

        // Bubble: beat looks accepted but is discarded
        out_ready = 1'b0;
        push(32'h11);
        bubble   = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_DEAD;
        #2;
        chk("bub_ready", 32'(in_ready2), 32'd1);
        tick();
        bubble   = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("bub_count", 32'(count2), 32'd1);
        chk("bub_head",  out_data2, 32'h11);
        out_ready = 1'b1;
        tick();
        #2;
        chk("bub_empty", 32'(out_valid2), 32'd0);
        chk("bub_nodead", out_data2, 32'h0000_0013);

        // Flush with two entries plus a push in the same cycle
        out_ready = 1'b0;
        push(32'h21);
        push(32'h22);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h23;
        #2;
        chk("fl_ready", 32'(in_ready3), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("fl_count",  32'(count2), 32'd0);
        chk("fl_valid",  32'(out_valid2), 32'd0);
        chk("fl_data",   out_data2, 32'h0000_0013);
        chk("fl_count3", 32'(count3), 32'd0);

        // Stall with bubble: stall wins, nothing changes
        push(32'h31);
        stall     = 1'b1;
        bubble    = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h32;
        out_ready = 1'b1;
        tick();
        stall    = 1'b0;
        bubble   = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("sb_count", 32'(count2), 32'd1);
        chk("sb_data",  out_data2, 32'h31);

        // Asynchronous reset empties immediately, mid-cycle
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count2), 32'd0);
        chk("arst_valid", 32'(out_valid3), 32'd0);
        chk("arst_data",  out_data2, 32'h0000_0013);
        tick();
        #2;
        rst_n = 1'b1;
        tick();

        // Hazard pattern for the perf counters
        stall = 1'b1;
        repeat (4) tick();
        stall  = 1'b0;
        bubble = 1'b1;
        repeat (2) tick();
        stall = 1'b1;
        tick();
        bubble = 1'b0;
        flush  = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        tick();
        #2;
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_stall",  stall_cyc2,  32'd5);
        chk("perf_bubble", bubble_cyc2, 32'd2);
        chk("perf_flush",  flush_cyc2,  32'd1);
        chk("perf_stall3", stall_cyc3,  32'd5);
`endif
        chk("end_count", 32'(count2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage replacing the fixed, single-entry per-field stage registers between core stages. It stores up to DEPTH beats of a WIDTH-bit packed stage bundle (all control and data fields concatenated), keeps the existing stall/bubble hazard controls, adds a valid/ready handshake and a whole-stage flush, and returns a caller-supplied default bundle (a NOP) whenever it is empty. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is driven by the hazard unit.

## Interface
- WIDTH, 32: bit width of the packed stage bundle; must be 1 or greater.
- DEPTH, 2: number of buffer entries; must be 1 or greater; any integer is legal.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- in_valid  in  1  upstream presents a beat.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream bundle.
- default_val  in  WIDTH  NOP bundle, shown on out_data when the stage is empty; treated as quasi-static.
- stall  in  1  freeze: no push, no pop.
- bubble  in  1  kill the incoming beat.
- flush  in  1  discard all stored entries.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes the head.
- out_data  out  WIDTH  head entry, or default_val when empty.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage is a circular buffer with read pointer, write pointer and count. Pointers wrap from DEPTH-1 to 0; DEPTH does not need to be a power of 2.
- out_valid = (count != 0).
- out_data = the head entry when out_valid = 1, otherwise default_val. This is combinational from the stored head and default_val.
- in_ready = !stall && !flush && (count < DEPTH || (out_ready && count != 0)). Push into a full stage is allowed in the same cycle as a pop.
- push = in_valid && in_ready && !bubble.
- pop = out_valid && out_ready && !stall && !flush.
- Priority is flush > stall > bubble.
  - **flush**: count, read pointer and write pointer all go to 0 on the next edge. The incoming beat is dropped, and pop does not occur.
  - **stall**: all state holds, in_ready = 0, and out_data/out_valid remain stable.
  - **bubble** (no stall): in_ready follows the normal rule, so upstream sees the beat as accepted. The beat is discarded, and a pop can still occur.
- count update per edge:
  - +1 on push only;
  - −1 on pop only;
  - unchanged when push and pop occur together;
  - 0 on flush.
- Reset, while rst_n = 0:
  - count = 0 and both pointers = 0;
  - out_valid = 0 and out_data = default_val;
  - in_ready = 1 unless stall or flush is asserted;
  - storage contents are don't-care.
- Asserting reset mid-operation immediately empties the stage, with no edge required.

## Timing
- Latency: a beat pushed at edge N is visible on out_data with out_valid = 1 after edge N. The minimum is 1 cycle.
- Full throughput of 1 beat/cycle with out_ready held at 1, for any DEPTH.
- Combinational paths:
  - out_ready → in_ready;
  - stall/flush → in_ready;
  - default_val → out_data.
- There is no path from in_valid to out_valid within the same cycle.
- Boundary conditions:
  - **Empty, no push:** pop is suppressed, out_data = default_val.
  - **Full, out_ready = 0:** in_ready = 0.
  - **Full with pop:** the push is accepted and count stays at DEPTH.
  - **flush together with push:** the result is empty.
  - **stall together with bubble:** stall wins and nothing changes.
- DEPTH = 1 behaves as the legacy stage register plus handshake.

## Configuration
- Macro `PIPE_STAGE_PERF_EN`.
- **Defined:** adds outputs `stall_cycles` [31:0], `bubble_cycles` [31:0] and `flush_cycles` [31:0].
  - Each counter increments by 1 on every edge where the respective input is high.
  - Each counter wraps at 2^32.
  - Each counter resets to 0 under rst_n.
  - flush_cycles counts every flush cycle. stall_cycles counts only when flush = 0. bubble_cycles counts only when stall = 0 and flush = 0.
- **Undefined:** these ports and registers do not exist, and the functional behaviour is identical.

## Test plan
- **Reset:** drive rst_n = 0 with default_val = 0x00000013.
  - During reset: out_valid = 0, out_data = 0x00000013, count = 0.
  - Deassert rst_n, then push 0xA5A5A5A5: the next cycle shows out_valid = 1 and out_data = 0xA5A5A5A5.
- **Fill and drain:** DEPTH = 3, out_ready = 0. Push 1, 2, 3, then present 4.
  - After the third push: count = 3, in_ready = 0, and beat 4 is not accepted.
  - Then set out_ready = 1: the outputs are 1, 2, 3, 4 on consecutive cycles, then out_valid = 0.
- **Full with simultaneous pop:** DEPTH = 2, full with {7, 8}, out_ready = 1, push 9.
  - in_ready = 1 and count stays at 2.
  - The outputs are 7, 8, 9 in order.
- **Stall:** with {5, 6} buffered, hold stall = 1 for 3 cycles while in_valid = 1 and out_ready = 1.
  - in_ready = 0, out_data = 5 and count = 2 throughout.
  - After release, 5 pops on the first edge.
- **Bubble and flush:**
  - Bubble with in_valid = 1 and in_data = 0xDEAD: in_ready = 1, count is unchanged, and 0xDEAD never appears on out_data.
  - Flush with 2 entries buffered plus a push in the same cycle: the next cycle shows count = 0, out_valid = 0, out_data = default_val.
- **Perf (with `PIPE_STAGE_PERF_EN`):**
  - Apply 4 stall cycles, 2 bubble cycles, 1 cycle with stall and bubble together, and 1 cycle with flush and stall together.
  - Expected counts: stall_cycles = 5, bubble_cycles = 2, flush_cycles = 1.
